// File: rtl/controle_alarme_if.sv
// ============================================================================
// Module : controle_alarme_if
// Brief  : Keypad/sensor/siren bundle for the alarm sequencing FSM.
//          The master drives the keypad, password and sensor signals.
//          The slave (controle_alarme) drives the status outputs and siren.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface controle_alarme_if;
  logic       confirma;
  logic [3:0] senha_usuario;
  logic [3:0] senha_sistema;
  logic       y;
  logic       p;
  logic [4:1] j;
  logic       i;
  logic       alarme;
  logic       armado;
  logic       aguardando;
  logic       bloqueado;
  logic [1:0] tentativas;
  logic [2:0] estado;

  modport master (
    output confirma, senha_usuario, senha_sistema, y, p, j, i,
    input  alarme, armado, aguardando, bloqueado, tentativas, estado
  );

  modport slave (
    input  confirma, senha_usuario, senha_sistema, y, p, j, i,
    output alarme, armado, aguardando, bloqueado, tentativas, estado
  );
endinterface

`default_nettype wire

// File: rtl/controle_alarme.sv
// ============================================================================
// Module : controle_alarme
// Brief  : Sequencing FSM of the residential security system. Arms/disarms
//          from password submissions, applies exit and entry delays, counts
//          failed attempts with lockout, and drives the siren.
//          Optional macro SIRENE_PULSADA_EN: siren toggles every
//          PERIODO_SIRENE cycles while in DISPARO (steady high otherwise).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module controle_alarme #(
  parameter int ATRASO_SAIDA   = 16,
  parameter int ATRASO_ENTRADA = 8,
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_BLOQUEIO = 32,
  parameter int PERIODO_SIRENE = 4,
  parameter int LARG_CONT      = 8
) (
  input  wire logic         gerador_frequencia,
  input  wire logic         reset,
  controle_alarme_if.slave  bus
);

  localparam logic [2:0] DESARMADO = 3'd0;
  localparam logic [2:0] ARMANDO   = 3'd1;
  localparam logic [2:0] ARMADO    = 3'd2;
  localparam logic [2:0] ENTRADA   = 3'd3;
  localparam logic [2:0] DISPARO   = 3'd4;
  localparam logic [2:0] BLOQUEIO  = 3'd5;

  // Terminal counts are compared exactly, so the timer can never wrap.
  localparam logic [LARG_CONT-1:0] c_fim_saida   = LARG_CONT'(ATRASO_SAIDA - 1);
  localparam logic [LARG_CONT-1:0] c_fim_entrada = LARG_CONT'(ATRASO_ENTRADA - 1);
  localparam logic [LARG_CONT-1:0] c_fim_bloq    = LARG_CONT'(TEMPO_BLOQUEIO - 1);
  localparam logic [LARG_CONT-1:0] c_fim_periodo = LARG_CONT'(PERIODO_SIRENE - 1);
  localparam logic [1:0]           c_max_tent    = 2'(MAX_TENTATIVAS);

  logic [2:0]           r_estado, w_prox;
  logic [LARG_CONT-1:0] r_timer, w_timer_prox, w_timer_inc;
  logic [1:0]           r_tent, w_tent_prox, w_tent_inc;
  logic                 r_alarme, r_armado, r_aguardando, r_bloqueado;
  logic                 w_alarme_prox;
  logic                 w_ok, w_erro, w_tent_lim, w_inst, w_porta;

  assign w_ok        = bus.confirma & (bus.senha_usuario == bus.senha_sistema);
  assign w_erro      = bus.confirma & ~w_ok;
  assign w_inst      = (bus.y & (|bus.j)) | (~bus.y & bus.i);
  assign w_porta     = bus.y & bus.p;
  assign w_tent_inc  = r_tent + 2'd1;
  assign w_tent_lim  = (w_tent_inc == c_max_tent);
  assign w_timer_inc = r_timer + LARG_CONT'(1);

  // Next state and attempt counter: ok > timer expiry > sensor violation.
  always_comb begin
    w_prox      = r_estado;
    w_tent_prox = r_tent;
    case (r_estado)
      DESARMADO: begin
        if (w_ok) begin
          w_prox      = ARMANDO;
          w_tent_prox = 2'd0;
        end else if (w_erro) begin
          if (w_tent_lim) begin
            w_prox      = BLOQUEIO;
            w_tent_prox = 2'd0;
          end else begin
            w_tent_prox = w_tent_inc;
          end
        end
      end
      ARMANDO: begin
        // Sensors and wrong passwords do not affect the exit delay.
        if (w_ok) begin
          w_prox      = DESARMADO;
          w_tent_prox = 2'd0;
        end else if (r_timer == c_fim_saida) begin
          w_prox = ARMADO;
        end
      end
      ARMADO, ENTRADA, DISPARO: begin
        if (w_ok) begin
          w_prox      = DESARMADO;
          w_tent_prox = 2'd0;
        end else begin
          if (w_erro) w_tent_prox = w_tent_lim ? 2'd0 : w_tent_inc;
          if (w_erro && w_tent_lim)
            w_prox = DISPARO;
          else if (r_estado == ENTRADA && r_timer == c_fim_entrada)
            w_prox = DISPARO;
          else if (r_estado != DISPARO && w_inst)
            w_prox = DISPARO;
          else if (r_estado == ARMADO && w_porta)
            w_prox = ENTRADA;
        end
      end
      BLOQUEIO: begin
        if (r_timer == c_fim_bloq) w_prox = DESARMADO;
      end
      default: w_prox = DESARMADO;
    endcase
  end

  // Timer clears on every state change; in DISPARO it paces the siren.
  always_comb begin
    w_timer_prox = '0;
    if (w_prox == r_estado) begin
      case (r_estado)
        ARMANDO, ENTRADA, BLOQUEIO: w_timer_prox = w_timer_inc;
        DISPARO: w_timer_prox = (r_timer == c_fim_periodo) ? '0 : w_timer_inc;
        default: w_timer_prox = '0;
      endcase
    end
  end

`ifdef SIRENE_PULSADA_EN
  logic r_sirene, w_sirene_prox;

  // Siren phase: starts high on DISPARO entry, flips at each period end.
  always_comb begin
    if (r_estado != DISPARO)
      w_sirene_prox = 1'b1;
    else if (r_timer == c_fim_periodo)
      w_sirene_prox = ~r_sirene;
    else
      w_sirene_prox = r_sirene;
  end

  // Siren phase register.
  always_ff @(posedge gerador_frequencia) begin
    if (reset) r_sirene <= 1'b0;
    else       r_sirene <= w_sirene_prox;
  end

  assign w_alarme_prox = (w_prox == DISPARO) & w_sirene_prox;
`else
  assign w_alarme_prox = (w_prox == DISPARO);
`endif

  // State, timer, counter and registered status outputs.
  always_ff @(posedge gerador_frequencia) begin
    if (reset) begin
      r_estado     <= DESARMADO;
      r_timer      <= '0;
      r_tent       <= 2'd0;
      r_alarme     <= 1'b0;
      r_armado     <= 1'b0;
      r_aguardando <= 1'b0;
      r_bloqueado  <= 1'b0;
    end else begin
      r_estado     <= w_prox;
      r_timer      <= w_timer_prox;
      r_tent       <= w_tent_prox;
      r_alarme     <= w_alarme_prox;
      r_armado     <= (w_prox == ARMADO) | (w_prox == ENTRADA) | (w_prox == DISPARO);
      r_aguardando <= (w_prox == ARMANDO) | (w_prox == ENTRADA);
      r_bloqueado  <= (w_prox == BLOQUEIO);
    end
  end

  assign bus.alarme     = r_alarme;
  assign bus.armado     = r_armado;
  assign bus.aguardando = r_aguardando;
  assign bus.bloqueado  = r_bloqueado;
  assign bus.tentativas = r_tent;
  assign bus.estado     = r_estado;

endmodule

`default_nettype wire
